// File: rtl/lmem_arbiter.sv
// Local-memory bank arbiter: shares one bram between host line write, host line read
// and compute chunk read. Define LMEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module lmem_arbiter #(
  parameter int NUM_BITS = 512,
  parameter int OFF_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr_req,
  input  logic             host_rd_req,
  input  logic             chunk_req,
  output logic             host_wr_gnt,
  output logic             host_rd_gnt,
  output logic             chunk_gnt,
  output logic             line_read_from_host,
  output logic             line_write_to_host,
  output logic             chunk_read_from_bram,
  output logic [OFF_W-1:0] offset,
  output logic             byte_beat,
  output logic             chunk_valid,
  output logic             op_done
);

  localparam int BYTES = NUM_BITS / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_WR,
    S_HOST_RD,
    S_CHUNK_RD,
    S_CHUNK_WAIT
  } state_t;

  typedef enum logic [1:0] {
    REQ_WR    = 2'd0,
    REQ_RD    = 2'd1,
    REQ_CHUNK = 2'd2
  } req_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_beat;
  logic             r_host_wr_gnt;
  logic             r_host_rd_gnt;
  logic             r_chunk_gnt;
  logic             r_line_read_from_host;
  logic             r_line_write_to_host;
  logic             r_chunk_read_from_bram;
  logic [OFF_W-1:0] r_offset;
  logic             r_byte_beat;
  logic             r_chunk_valid;
  logic             r_op_done;

  logic             w_win_valid;
  req_t             w_win;

`ifdef LMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_win_valid = host_wr_req | host_rd_req | chunk_req;
    w_win       = REQ_WR;
    if (host_wr_req)      w_win = REQ_WR;
    else if (host_rd_req) w_win = REQ_RD;
    else if (chunk_req)   w_win = REQ_CHUNK;
  end
`else
  // r_rr_ptr names the requester that has first claim on the next decision.
  req_t r_rr_ptr;
  req_t w_next_ptr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_win_valid = host_wr_req | host_rd_req | chunk_req;
    w_win       = REQ_WR;
    case (r_rr_ptr)
      REQ_RD: begin
        if (host_rd_req)      w_win = REQ_RD;
        else if (chunk_req)   w_win = REQ_CHUNK;
        else if (host_wr_req) w_win = REQ_WR;
      end
      REQ_CHUNK: begin
        if (chunk_req)        w_win = REQ_CHUNK;
        else if (host_wr_req) w_win = REQ_WR;
        else if (host_rd_req) w_win = REQ_RD;
      end
      default: begin
        if (host_wr_req)      w_win = REQ_WR;
        else if (host_rd_req) w_win = REQ_RD;
        else if (chunk_req)   w_win = REQ_CHUNK;
      end
    endcase
    case (w_win)
      REQ_WR:  w_next_ptr = REQ_RD;
      REQ_RD:  w_next_ptr = REQ_CHUNK;
      default: w_next_ptr = REQ_WR;
    endcase
  end
`endif

  // Outputs are registered from the current state, so strobes trail state entry by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state                <= S_IDLE;
      r_beat                 <= '0;
      r_host_wr_gnt          <= 1'b0;
      r_host_rd_gnt          <= 1'b0;
      r_chunk_gnt            <= 1'b0;
      r_line_read_from_host  <= 1'b0;
      r_line_write_to_host   <= 1'b0;
      r_chunk_read_from_bram <= 1'b0;
      r_offset               <= '0;
      r_byte_beat            <= 1'b0;
      r_chunk_valid          <= 1'b0;
      r_op_done              <= 1'b0;
`ifndef LMEM_ARB_FIXED_PRIO_EN
      r_rr_ptr               <= REQ_WR;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_host_wr_gnt          <= 1'b0;
      r_host_rd_gnt          <= 1'b0;
      r_chunk_gnt            <= 1'b0;
      r_line_read_from_host  <= 1'b0;
      r_line_write_to_host   <= 1'b0;
      r_chunk_read_from_bram <= 1'b0;
      r_offset               <= '0;
      r_byte_beat            <= 1'b0;
      r_chunk_valid          <= 1'b0;
      r_op_done              <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (w_win_valid) begin
            case (w_win)
              REQ_WR:  r_state <= S_HOST_WR;
              REQ_RD:  r_state <= S_HOST_RD;
              default: r_state <= S_CHUNK_RD;
            endcase
`ifndef LMEM_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_next_ptr;
`endif
          end
        end

        S_HOST_WR, S_HOST_RD: begin
          r_host_wr_gnt         <= (r_state == S_HOST_WR);
          r_line_read_from_host <= (r_state == S_HOST_WR);
          r_host_rd_gnt         <= (r_state == S_HOST_RD);
          r_line_write_to_host  <= (r_state == S_HOST_RD);
          r_byte_beat           <= 1'b1;
          r_offset              <= OFF_W'({r_beat, 3'b000});
          if (r_beat == CNT_W'(BYTES - 1)) begin
            r_op_done <= 1'b1;
            r_beat    <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end

        S_CHUNK_RD: begin
          r_chunk_gnt            <= 1'b1;
          r_chunk_read_from_bram <= 1'b1;
          r_state                <= S_CHUNK_WAIT;
        end

        S_CHUNK_WAIT: begin
          r_chunk_valid <= 1'b1;
          r_op_done     <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host_wr_gnt          = r_host_wr_gnt;
  assign host_rd_gnt          = r_host_rd_gnt;
  assign chunk_gnt            = r_chunk_gnt;
  assign line_read_from_host  = r_line_read_from_host;
  assign line_write_to_host   = r_line_write_to_host;
  assign chunk_read_from_bram = r_chunk_read_from_bram;
  assign offset               = r_offset;
  assign byte_beat            = r_byte_beat;
  assign chunk_valid          = r_chunk_valid;
  assign op_done              = r_op_done;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Scoreboard bench for lmem_arbiter: a transaction-level model schedules expected
// per-cycle outputs and grants; a negedge monitor pops and compares.
module tb_lmem_arbiter;

  localparam int BYTES = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_wr_req = 1'b0;
  logic       host_rd_req = 1'b0;
  logic       chunk_req = 1'b0;
  logic       host_wr_gnt, host_rd_gnt, chunk_gnt;
  logic       line_read_from_host, line_write_to_host, chunk_read_from_bram;
  logic [8:0] offset;
  logic       byte_beat, chunk_valid, op_done;

  lmem_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .host_wr_req         (host_wr_req),
    .host_rd_req         (host_rd_req),
    .chunk_req           (chunk_req),
    .host_wr_gnt         (host_wr_gnt),
    .host_rd_gnt         (host_rd_gnt),
    .chunk_gnt           (chunk_gnt),
    .line_read_from_host (line_read_from_host),
    .line_write_to_host  (line_write_to_host),
    .chunk_read_from_bram(chunk_read_from_bram),
    .offset              (offset),
    .byte_beat           (byte_beat),
    .chunk_valid         (chunk_valid),
    .op_done             (op_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr_gnt;
    logic       rd_gnt;
    logic       ch_gnt;
    logic       s_from_host;
    logic       s_to_host;
    logic       s_chunk;
    logic       byte_beat;
    logic       chunk_valid;
    logic       op_done;
    logic [8:0] offset;
  } out_t;

  typedef struct {
    int kind;   // 0 host write, 1 host read, 2 chunk read
    int start;  // cycle of the first visible grant
  } txn_t;

  out_t exp_vec [int];
  txn_t txn_q [$];
  int   cyc = 0;
  int   m_free = 0;
  int   m_ptr = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_g = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic out_t dut_vec();
    out_t v;
    v.wr_gnt      = host_wr_gnt;
    v.rd_gnt      = host_rd_gnt;
    v.ch_gnt      = chunk_gnt;
    v.s_from_host = line_read_from_host;
    v.s_to_host   = line_write_to_host;
    v.s_chunk     = chunk_read_from_bram;
    v.byte_beat   = byte_beat;
    v.chunk_valid = chunk_valid;
    v.op_done     = op_done;
    v.offset      = offset;
    return v;
  endfunction

  function automatic out_t host_beat(input int kind, input int b);
    out_t v = '0;
    v.wr_gnt      = (kind == 0);
    v.s_from_host = (kind == 0);
    v.rd_gnt      = (kind == 1);
    v.s_to_host   = (kind == 1);
    v.byte_beat   = 1'b1;
    v.offset      = 9'(b * 8);
    v.op_done     = (b == BYTES - 1);
    return v;
  endfunction

  // Reference model: one decision per free edge; host ops show 64 beats starting one
  // cycle after the decision edge, chunk ops show 2 cycles; one quiet cycle follows each op.
  always @(posedge clk or posedge rst) begin
    logic [2:0] reqs;
    int         win;
    int         idx;
    out_t       v;
    if (rst) begin
      exp_vec.delete();
      txn_q.delete();
      m_ptr  = 0;
      m_free = 0;
    end else begin
      cyc++;
      reqs = {chunk_req, host_rd_req, host_wr_req};
      win  = -1;
      if (cyc >= m_free) begin
`ifdef LMEM_ARB_FIXED_PRIO_EN
        for (int k = 2; k >= 0; k--) if (reqs[k]) win = k;
`else
        for (int k = 2; k >= 0; k--) begin
          idx = (m_ptr + k) % 3;
          if (reqs[idx]) win = idx;
        end
`endif
      end
      if (win >= 0) begin
        m_ptr = (win + 1) % 3;
        txn_q.push_back('{kind: win, start: cyc + 1});
        if (win < 2) begin
          for (int b = 0; b < BYTES; b++) exp_vec[cyc + 1 + b] = host_beat(win, b);
          m_free = cyc + BYTES + 1;
        end else begin
          v = '0; v.ch_gnt = 1'b1; v.s_chunk = 1'b1;
          exp_vec[cyc + 1] = v;
          v = '0; v.chunk_valid = 1'b1; v.op_done = 1'b1;
          exp_vec[cyc + 2] = v;
          m_free = cyc + 3;
        end
      end
    end
  end

  // Monitor: compares every cycle, pops a transaction on each grant start.
  always @(negedge clk) begin
    out_t act;
    out_t exp;
    logic any_g;
    txn_t t;
    if (rst) begin
      prev_g = 1'b0;
    end else begin
      act = dut_vec();
      exp = exp_vec.exists(cyc) ? exp_vec[cyc] : '0;
      if (exp_vec.exists(cyc)) exp_vec.delete(cyc);
      check("cycle_outputs", 32'(act), 32'(exp));
      check("strobe_onehot", 32'($countones({act.s_from_host, act.s_to_host, act.s_chunk}) <= 1), 32'd1);
      check("offset_range", 32'(act.offset <= 9'd504), 32'd1);
      any_g = act.wr_gnt | act.rd_gnt | act.ch_gnt;
      if (any_g && !prev_g) begin
        if (txn_q.size() == 0) begin
          check("grant_unexpected", {29'd0, act.wr_gnt, act.rd_gnt, act.ch_gnt}, 32'd0);
        end else begin
          t = txn_q.pop_front();
          check("grant_kind", {29'd0, act.wr_gnt, act.rd_gnt, act.ch_gnt}, 32'(3'b100 >> t.kind));
          check("grant_cycle", 32'(cyc), 32'(t.start));
        end
      end
      prev_g = any_g;
    end
  end

  task automatic wait_offset(input logic [8:0] target, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (offset == target) return;
    end
    check(name, 32'(offset), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int found;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    rst = 1'b0;

    // Single host write line.
    host_wr_req = 1'b1;
    repeat (3) @(negedge clk);
    host_wr_req = 1'b0;
    wait_offset(9'd504, "wr_reach_504");
    check("wr_done_at_504", {31'd0, op_done}, 32'd1);
    @(negedge clk);
    check("wr_offset_back_0", 32'(offset), 32'd0);
    repeat (4) @(negedge clk);

    // Chunk pulse while idle.
    chunk_req = 1'b1;
    @(negedge clk);
    chunk_req = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (chunk_read_from_bram) found = 1;
    end
    check("chunk_strobe_seen", 32'(found), 32'd1);
    check("chunk_offset", 32'(offset), 32'd0);
    @(negedge clk);
    check("chunk_valid_done", {30'd0, chunk_valid, op_done}, 32'd3);
    check("chunk_no_host", {30'd0, line_read_from_host, line_write_to_host}, 32'd0);
    repeat (4) @(negedge clk);

    // All three requests held from reset: order comes from the scoreboard.
    host_wr_req = 1'b1; host_rd_req = 1'b1; chunk_req = 1'b1;
    do_reset();
    repeat (220) @(negedge clk);
    host_wr_req = 1'b0; host_rd_req = 1'b0; chunk_req = 1'b0;
    repeat (80) @(negedge clk);

    // Host read with request dropped at beat 10.
    host_rd_req = 1'b1;
    wait_offset(9'd80, "rd_reach_beat10");
    host_rd_req = 1'b0;
    wait_offset(9'd504, "rd_reach_504");
    check("rd_done_at_504", {30'd0, op_done, host_rd_gnt}, 32'd3);
    repeat (4) @(negedge clk);

    // Asynchronous reset at beat 30 of a host write.
    host_wr_req = 1'b1;
    wait_offset(9'd240, "wr_reach_beat30");
    host_wr_req = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_reset_clear", 32'(dut_vec()), 32'd0);
    repeat (2) @(negedge clk);
    check("reset_hold_clear", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    host_wr_req = 1'b1; host_rd_req = 1'b1; chunk_req = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (host_wr_gnt | host_rd_gnt | chunk_gnt) found = 1;
    end
    check("post_reset_first", {29'd0, host_wr_gnt, host_rd_gnt, chunk_gnt}, 32'd4);
    host_wr_req = 1'b0; host_rd_req = 1'b0; chunk_req = 1'b0;
    repeat (80) @(negedge clk);

    // Random request traffic.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) host_wr_req = ~host_wr_req;
      if ($urandom_range(0, 15) == 0) host_rd_req = ~host_rd_req;
      if ($urandom_range(0, 7) == 0)  chunk_req   = ~chunk_req;
    end
    host_wr_req = 1'b0; host_rd_req = 1'b0; chunk_req = 1'b0;
    repeat (80) @(negedge clk);
    check("drain_txn", 32'(txn_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lmem_arbiter.md
Name: lmem_arbiter

Overview:
- Controller and arbiter for the local-memory bank: one 512-bit wide chunk port and one 8-bit host byte port.
- Shares the bank between three requesters:
  - host line write (host -> bram, 64 bytes)
  - host line read (bram -> host, 64 bytes)
  - compute chunk read (one 512-bit word)
- Produces the bank's control strobes and the bit offset, and sequences the 64-beat byte transfers.
- Only one operation owns the bank at a time.

Parameters:
- NUM_BITS, 512, width of one memory line/chunk in bits; must be a multiple of 8.
- BYTES, NUM_BITS/8, bytes per line; derived, do not override.
- OFF_W, 9, width of bit-offset output; must hold (BYTES-1)*8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_wr_req  in  1  level request: host writes one line into bram.
- host_rd_req  in  1  level request: host reads one line out of bram.
- chunk_req  in  1  level request: compute unit reads one chunk.
- host_wr_gnt  out  1  high while a host write operation owns the bank.
- host_rd_gnt  out  1  high while a host read operation owns the bank.
- chunk_gnt  out  1  high for the single chunk-read cycle.
- line_read_from_host  out  1  bram strobe: latch host_input byte at offset.
- line_write_to_host  out  1  bram strobe: drive byte at offset onto bram_to_host.
- chunk_read_from_bram  out  1  bram strobe: drive full chunk onto chunk_out.
- offset  out  OFF_W  bit offset of current byte = beat*8.
- byte_beat  out  1  host byte handshake: byte consumed/produced this cycle.
- chunk_valid  out  1  chunk_out valid; one cycle, one clock after chunk_read_from_bram.
- op_done  out  1  one-cycle pulse on last cycle of any operation.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0, offset 0, beat counter 0.
  - Round-robin pointer = host_wr.
- Reset asserted mid-operation aborts it. No op_done is produced. A partial line in bram is left as is.
- FSM states: IDLE, HOST_WR, HOST_RD, CHUNK_RD, CHUNK_WAIT.
- IDLE:
  - Samples requests each cycle. No request: stay in IDLE.
  - With one or more requests: choose round-robin starting after the last granted requester (order host_wr -> host_rd -> chunk).
  - Go to the chosen state on the next edge and update the pointer to the winner.
  - IDLE emits no strobes.
- HOST_WR (BYTES cycles):
  - host_wr_gnt=1, line_read_from_host=1, byte_beat=1 every cycle.
  - Beat counter runs 0..BYTES-1; offset = beat*8 (0, 8, ..., 504).
  - On beat BYTES-1: op_done=1, then return to IDLE, counter cleared, offset 0.
- HOST_RD (BYTES cycles): identical sequencing, but drives line_write_to_host instead of line_read_from_host, and host_rd_gnt instead of host_wr_gnt.
- CHUNK_RD (1 cycle): chunk_gnt=1, chunk_read_from_bram=1, offset 0.
- CHUNK_WAIT (1 cycle): chunk_valid=1, op_done=1, then return to IDLE.
- Counter width: ceil(log2(BYTES)). Terminal compare is against BYTES-1; no wrap past it.
- Offset arithmetic uses OFF_W bits. No truncation is allowed, since (BYTES-1)*8 fits by parameter rule.
- Requests are not re-sampled during an operation. Deasserting a request mid-operation does not abort it; the operation runs to completion.
- A requester holding its request after op_done is eligible again. Round-robin guarantees the others are served first if they are pending.
- Minimum gap: one IDLE cycle between consecutive operations.
- Strobes are mutually exclusive; at most one of the three bram strobes is high in any cycle.
- All outputs are registered. Latency from request to first strobe is 2 edges (IDLE decision, then state entry).

Optional Feature:
- Macro: LMEM_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority host_wr > host_rd > chunk. The pointer register is removed. All other timing is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then host_wr_req held 1 -> host_wr_gnt high for exactly 64 cycles; offset steps 0, 8, ..., 504; op_done pulses with offset=504; returns to 0.
- chunk_req pulse while idle -> chunk_read_from_bram for 1 cycle at offset 0; chunk_valid and op_done next cycle; no host strobes.
- host_wr_req, host_rd_req and chunk_req all asserted and held from reset -> grant order host_wr, host_rd, chunk, host_wr. Without LMEM_ARB_FIXED_PRIO_EN: round-robin order as listed. With LMEM_ARB_FIXED_PRIO_EN: host_wr, host_wr, ... with chunk never granted.
- host_rd_req asserted then dropped at beat 10 -> transfer still completes 64 beats and op_done fires at beat 63.
- rst asserted asynchronously at beat 30 of HOST_WR -> all outputs 0 immediately without waiting for a clock edge; no op_done; next grant after release follows the reset pointer (host_wr first).
- Every cycle across all scenarios -> at most one bram strobe high, and offset never exceeds 504.
